// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: holds the pipeline while a variable-latency data access
// is outstanding, then releases the result into MEM/WB for one cycle.
// state  | meaning
// S_IDLE | no access in flight; non-memory ops pass straight through
// S_WAIT | dmem_req high, waiting for dmem_ready or timeout
// S_RESP | one-cycle release of the completed access into MEM/WB
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ex_mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [1:0]  control_wb_in,
  input  logic [4:0]  write_reg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [1:0]  control_wb_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  write_reg_out,
  output logic        bus_error,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [4:0]         reg_q, reg_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [31:0]        err_addr_q, err_addr_d;
  logic               is_mem;

  assign is_mem = ex_mem_valid & (mem_read | mem_write);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ctrl_d     = ctrl_q;
    reg_d      = reg_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = addr_in;
          wdata_d = wdata_in;
          ctrl_d  = control_wb_in;
          reg_d   = write_reg_in;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response in the final allowed cycle still wins over the timeout.
        if (dmem_ready) begin
          rdata_d = we_q ? 32'h0 : dmem_rdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d    = 32'h0;
          req_d      = 1'b0;
          we_d       = 1'b0;
          err_d      = 1'b1;
          err_addr_d = addr_q;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ctrl_q     <= '0;
      reg_q      <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ctrl_q     <= ctrl_d;
      reg_q      <= reg_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign err_addr   = err_addr_q;

  // Gated by reset_n so the pipeline is never frozen while in reset.
  always_comb begin
    stall          = 1'b0;
    control_wb_out = 2'b00;
    read_data_out  = 32'h0;
    alu_result_out = addr_in;
    write_reg_out  = write_reg_in;
    bus_error      = 1'b0;
    if (reset_n) begin
      case (state_q)
        S_IDLE: begin
          stall = is_mem;
          if (ex_mem_valid && !is_mem) control_wb_out = control_wb_in;
        end
        S_WAIT: begin
          stall          = 1'b1;
          alu_result_out = addr_q;
          write_reg_out  = reg_q;
        end
        S_RESP: begin
          alu_result_out = addr_q;
          write_reg_out  = reg_q;
          read_data_out  = rdata_q;
          control_wb_out = err_q ? 2'b00 : ctrl_q;
          bus_error      = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: vector table driven through a
// scoreboard queue, a behavioural data memory, and a mid-access reset sequence.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_mem_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] addr_in = '0, wdata_in = '0;
  logic [1:0]  control_wb_in = '0;
  logic [4:0]  write_reg_in = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        stall;
  logic [1:0]  control_wb_out;
  logic [31:0] read_data_out, alu_result_out;
  logic [4:0]  write_reg_out;
  logic        bus_error;
  logic [31:0] err_addr;

  mem_stage_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .ex_mem_valid(ex_mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .addr_in(addr_in), .wdata_in(wdata_in), .control_wb_in(control_wb_in),
    .write_reg_in(write_reg_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall(stall), .control_wb_out(control_wb_out), .read_data_out(read_data_out),
    .alu_result_out(alu_result_out), .write_reg_out(write_reg_out),
    .bus_error(bus_error), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        valid, rd, wr;
    logic [31:0] addr, wdata;
    logic [1:0]  ctrl;
    logic [4:0]  wreg;
    logic [31:0] rdata;
    int          delay;      // req cycles before ready; -1 = never
    logic        hold;       // ready held high permanently
    logic        chk_dp;     // check alu_result/write_reg
    logic        chk_rd;     // check read_data
    logic [1:0]  e_ctrl;
    logic [31:0] e_rdata;
    int          e_stall, e_req;
    logic        e_berr;
    logic [31:0] e_erraddr;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];
  vec_t sb[$];

  // behavioural data memory
  int          ready_delay = -1;
  logic        hold_ready = 1'b0;
  int          req_cycles = 0;
  always @(posedge clk) begin
    #2;
    if (dmem_req) begin
      dmem_ready = hold_ready || (ready_delay >= 0 && req_cycles == ready_delay);
      req_cycles++;
    end else begin
      dmem_ready = hold_ready;
      req_cycles = 0;
    end
  end

  // request-channel stability monitor
  int          req_hi_cnt = 0;
  logic        mon_we = 1'b0;
  logic [31:0] mon_addr = '0, mon_wdata = '0;
  always @(negedge clk) begin
    if (reset_n && dmem_req) begin
      req_hi_cnt++;
      chk("req_we", dmem_we, mon_we);
      chk("req_addr", dmem_addr, mon_addr);
      if (mon_we) chk("req_wdata", dmem_wdata, mon_wdata);
    end
  end

  initial begin
    vec_t v, e;
    int   stall_cnt;
    logic got;

    //         vld rd wr addr           wdata         ctrl   reg rdata          dly hold dp rd  e_ctrl e_rdata        st  rq berr erraddr
    vecs[0] = '{1'b1,1'b0,1'b0,32'h0000_0040,32'h0,        2'b10,5'd5, 32'h0,        0, 1'b0,1'b1,1'b1,2'b10,32'h0,        0, 0, 1'b0,32'h0};
    vecs[1] = '{1'b1,1'b1,1'b0,32'h0000_0100,32'h0,        2'b11,5'd8, 32'hDEAD_BEEF,0, 1'b1,1'b1,1'b1,2'b11,32'hDEAD_BEEF,2, 1, 1'b0,32'h0};
    vecs[2] = '{1'b1,1'b0,1'b1,32'h0000_0200,32'h0000_1234,2'b01,5'd12,32'hAAAA_5555,4, 1'b0,1'b1,1'b1,2'b01,32'h0,        6, 5, 1'b0,32'h0};
    vecs[3] = '{1'b0,1'b0,1'b0,32'h0000_0abc,32'h0,        2'b11,5'd6, 32'h0,        0, 1'b0,1'b0,1'b1,2'b00,32'h0,        0, 0, 1'b0,32'h0};
    vecs[4] = '{1'b1,1'b1,1'b1,32'h0000_0044,32'hCAFE_0001,2'b10,5'd3, 32'h0000_0077,1, 1'b0,1'b1,1'b1,2'b10,32'h0,        3, 2, 1'b0,32'h0};
    vecs[5] = '{1'b1,1'b1,1'b0,32'h0000_0300,32'h0,        2'b11,5'd9, 32'h1111_2222,-1,1'b0,1'b1,1'b0,2'b00,32'h0,        17,16,1'b1,32'h0000_0300};
    vecs[6] = '{1'b1,1'b1,1'b0,32'h0000_0008,32'h0,        2'b01,5'd2, 32'h0000_005A,15,1'b0,1'b1,1'b1,2'b01,32'h0000_005A,17,16,1'b0,32'h0000_0300};
    vecs[7] = '{1'b1,1'b0,1'b0,32'hFFFF_FFFC,32'h0,        2'b01,5'd31,32'h0,        0, 1'b0,1'b1,1'b1,2'b01,32'h0,        0, 0, 1'b0,32'h0000_0300};

    // reset state, with a load presented to show reset dominates
    ex_mem_valid = 1'b1; mem_read = 1'b1; addr_in = 32'h0000_0500; control_wb_in = 2'b11;
    #12;
    chk("rst_stall", stall, 1'b0);
    chk("rst_ctrl", control_wb_out, 2'b00);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_we", dmem_we, 1'b0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_berr", bus_error, 1'b0);
    chk("rst_erraddr", err_addr, 32'h0);
    ex_mem_valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      @(posedge clk); #1;
      ex_mem_valid = v.valid; mem_read = v.rd; mem_write = v.wr;
      addr_in = v.addr; wdata_in = v.wdata; control_wb_in = v.ctrl; write_reg_in = v.wreg;
      dmem_rdata = v.rdata; ready_delay = v.delay; hold_ready = v.hold;
      mon_we = v.wr; mon_addr = v.addr; mon_wdata = v.wdata;
      req_hi_cnt = 0;
      sb.push_back(v);
      stall_cnt = 0;
      got = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (!stall) begin
          got = 1'b1;
          break;
        end
        stall_cnt++;
      end
      e = sb.pop_front();
      if (!got) begin
        checks++; failures++;
        $display("FAIL v%0d_release actual=stall_stuck required=stall_low", i);
      end else begin
        chk($sformatf("v%0d_ctrl", i), control_wb_out, e.e_ctrl);
        if (e.chk_rd) chk($sformatf("v%0d_rdata", i), read_data_out, e.e_rdata);
        if (e.chk_dp) begin
          chk($sformatf("v%0d_alu", i), alu_result_out, e.addr);
          chk($sformatf("v%0d_wreg", i), write_reg_out, e.wreg);
        end
        chk($sformatf("v%0d_stall_cycles", i), stall_cnt, e.e_stall);
        chk($sformatf("v%0d_req_cycles", i), req_hi_cnt, e.e_req);
        chk($sformatf("v%0d_berr", i), bus_error, e.e_berr);
        chk($sformatf("v%0d_erraddr", i), err_addr, e.e_erraddr);
      end
      ex_mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_berr_clear", i), bus_error, 1'b0);
      chk($sformatf("v%0d_idle_req", i), dmem_req, 1'b0);
      chk($sformatf("v%0d_idle_stall", i), stall, 1'b0);
    end

    // reset asserted in the 3rd WAIT cycle of a hung load
    @(posedge clk); #1;
    ex_mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    addr_in = 32'h0000_0400; control_wb_in = 2'b11; write_reg_in = 5'd4;
    ready_delay = -1; hold_ready = 1'b0;
    mon_we = 1'b0; mon_addr = 32'h0000_0400;
    repeat (3) @(posedge clk);
    #2;
    chk("ar_req_before", dmem_req, 1'b1);
    chk("ar_stall_before", stall, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("ar_req", dmem_req, 1'b0);
    chk("ar_stall", stall, 1'b0);
    chk("ar_ctrl", control_wb_out, 2'b00);
    @(negedge clk);
    chk("ar_erraddr", err_addr, 32'h0);
    ex_mem_valid = 1'b1; mem_read = 1'b0; addr_in = 32'h0000_0055;
    control_wb_in = 2'b01; write_reg_in = 5'd7;
    reset_n = 1'b1;
    #2;
    chk("ar_pass_ctrl", control_wb_out, 2'b01);
    chk("ar_pass_alu", alu_result_out, 32'h0000_0055);
    chk("ar_pass_wreg", write_reg_out, 5'd7);
    @(posedge clk);
    @(negedge clk);
    chk("ar_post_ctrl", control_wb_out, 2'b01);
    chk("ar_post_rdata", read_data_out, 32'h0);
    chk("ar_post_req", dmem_req, 1'b0);
    chk("ar_post_stall", stall, 1'b0);
    chk("ar_post_berr", bus_error, 1'b0);
    ex_mem_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Sequences the MEM stage of the MIPS pipeline against a variable-latency data memory using a req/ready handshake.
- Holds the upstream pipeline (PC, IF/ID, ID/EX, EX/MEM) while an access is outstanding.
- Injects bubbles into the MEM/WB register during the stall, then releases the completed instruction into MEM/WB in one cycle.
- Enforces a timeout: a hung access is reported as a bus error and its writeback is killed.

Parameters:
- TIMEOUT, 16, maximum cycles dmem_req may stay high without dmem_ready before the access is aborted (must be ≥2).
- CNT_W, 5, width of the wait counter; must hold TIMEOUT-1.

Ports:
- clk  input  1  pipeline clock
- reset_n  input  1  asynchronous active-low reset
- ex_mem_valid  input  1  EX/MEM holds a live instruction
- mem_read  input  1  instruction is a load
- mem_write  input  1  instruction is a store
- addr_in  input  32  ALU result / memory address from EX/MEM
- wdata_in  input  32  store data from EX/MEM
- control_wb_in  input  2  WB control bits from EX/MEM
- write_reg_in  input  5  destination register from EX/MEM
- dmem_req  output  1  memory request, registered
- dmem_we  output  1  write enable, valid while dmem_req=1
- dmem_addr  output  32  latched address
- dmem_wdata  output  32  latched store data
- dmem_ready  input  1  memory completes the access this cycle
- dmem_rdata  input  32  load data, valid when dmem_ready=1
- stall  output  1  freeze all upstream pipeline registers and PC
- control_wb_out  output  2  to MEM/WB control_wb_in; 0 = bubble
- read_data_out  output  32  to MEM/WB read_data_in
- alu_result_out  output  32  to MEM/WB alu_result_in
- write_reg_out  output  5  to MEM/WB write_reg_in
- bus_error  output  1  one-cycle pulse on timeout
- err_addr  output  32  address of the last timed-out access (sticky)

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State goes to IDLE.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - Wait counter=0, bus_error=0, err_addr=0.
  - While reset is asserted: stall=0 and control_wb_out=0, regardless of inputs.
  - Reset asserted mid-access drops dmem_req immediately; the access is abandoned and no writeback is produced.
- State IDLE:
  - Non-memory instruction (ex_mem_valid=1, mem_read=0, mem_write=0):
    - Outputs pass through combinationally: control_wb_out=control_wb_in, alu_result_out=addr_in, write_reg_out=write_reg_in, read_data_out=0.
    - stall=0.
  - ex_mem_valid=0: control_wb_out=0, stall=0.
  - Memory instruction (ex_mem_valid=1 and (mem_read|mem_write)):
    - stall=1 combinationally, control_wb_out=0 (bubble).
    - On the clock edge, latch addr, wdata, we=mem_write, control_wb_in, write_reg_in; set dmem_req=1; clear the counter; go to WAIT.
  - mem_read and mem_write both 1 is treated as a store.
- State WAIT:
  - stall=1, control_wb_out=0; dmem_req/addr/we/wdata are held stable.
  - dmem_ready=1: capture dmem_rdata (store: capture 0), drop dmem_req, go to RESP.
  - Else, if counter==TIMEOUT-1: drop dmem_req, set the error flag, load err_addr, go to RESP.
  - Else: counter+1.
  - dmem_ready while dmem_req=0 is ignored in every state.
- State RESP (exactly one cycle):
  - stall=0, so upstream advances and MEM/WB captures this instruction.
  - read_data_out=captured data, alu_result_out=latched addr, write_reg_out=latched reg.
  - control_wb_out=latched control, or 0 if the error flag is set; bus_error=1 if the error flag is set.
  - Next state is IDLE; the error flag is cleared.
  - A new memory instruction is evaluated in the following IDLE cycle (no back-to-back overlap).
- Latency: with dmem_ready in the first dmem_req cycle, stall is high for 2 cycles and the result reaches MEM/WB on the 3rd edge. Each extra wait cycle adds 1.
- Timeout: dmem_req is high for exactly TIMEOUT cycles.

Test Plan:
- Non-memory op, control_wb_in=2'b10, addr_in=0x0000_0040, write_reg_in=5 → same cycle: stall=0, control_wb_out=2'b10, alu_result_out=0x40, write_reg_out=5, read_data_out=0, dmem_req never asserted.
- Load addr 0x100, reg 8, control 2'b11, dmem_ready held high → stall=1 for 2 cycles, dmem_req=1 for 1 cycle with dmem_we=0; RESP cycle: read_data_out=dmem_rdata (0xDEADBEEF), control_wb_out=2'b11, write_reg_out=8, stall=0.
- Store addr 0x200, wdata 0x1234, ready after 4 wait cycles → dmem_we=1 and dmem_addr/dmem_wdata stable for all 5 dmem_req cycles; stall high 6 cycles; RESP control_wb_out=control_wb_in latched, read_data_out=0.
- Load to 0x300 with dmem_ready never asserted, TIMEOUT=16 → dmem_req high exactly 16 cycles; RESP: bus_error=1 for one cycle, control_wb_out=0, err_addr=0x300; state returns to IDLE.
- reset_n pulled low in the 3rd WAIT cycle → dmem_req=0 and stall=0 immediately (asynchronous); after release the FSM is in IDLE and a following non-memory op passes through with no writeback of the aborted load.
